// File: rtl/uart_time_cmd.sv
// uart_time_cmd: paces uart_rx with an oversample tick and parses "T"+HHMMSS+CR/LF time-set frames.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   oversample_tick     : one-cycle pulse at BAUD*OVERSAMPLE for uart_rx
//   rx_data, rx_valid   : received byte and its single-cycle strobe
//   framing_error       : receiver stop-bit error pulse
//   set_valid, set_time : one-cycle pulse with packed-BCD HHMMSS of an accepted frame
//   cmd_error, err_code : one-cycle rejection pulse; code 0 char, 1 range, 2 framing, 3 timeout
//   busy                : a frame is in progress
module uart_time_cmd #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_TICKS = 1600
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        oversample_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        framing_error,
  output logic        set_valid,
  output logic [23:0] set_time,
  output logic        cmd_error,
  output logic [1:0]  err_code,
  output logic        busy
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_t;
  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [TW-1:0]   timer;
  logic [2:0]      idx;
  logic [23:0]     stage;
  logic            is_digit, is_eol, is_t, range_ok, timeout;
  assign oversample_tick = div_cnt == DW'(DIV - 1);
  assign busy     = state != IDLE;
  assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_eol   = rx_data == 8'h0d || rx_data == 8'h0a;
  assign is_t     = rx_data == 8'h54 || rx_data == 8'h74;
  // Digits are 0..9 by construction, so only the tens digits need bounding.
  assign range_ok = (stage[23:20] < 4'd2 || (stage[23:20] == 4'd2 && stage[19:16] <= 4'd3)) &&
                    stage[15:12] <= 4'd5 && stage[7:4] <= 4'd5;
  // Expiry is the cycle of the TIMEOUT_TICKS-th tick since the last accepted byte.
  assign timeout  = busy && oversample_tick && timer == TW'(TIMEOUT_TICKS - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_cnt <= '0;
    else div_cnt <= oversample_tick ? '0 : div_cnt + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      stage     <= '0;
      set_valid <= 1'b0;
      set_time  <= '0;
      cmd_error <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      set_valid <= 1'b0;
      cmd_error <= 1'b0;
      if (busy && oversample_tick) timer <= timer + 1'b1;
      // Framing errors outrank a coincident byte, which is dropped.
      if (framing_error) begin
        if (busy) begin
          state     <= IDLE;
          cmd_error <= 1'b1;
          err_code  <= 2'd2;
        end
      end else if (rx_valid) begin
        timer <= '0;
        unique case (state)
          IDLE: if (is_t) begin
            state <= DIGITS;
            idx   <= '0;
          end
          DIGITS: if (is_digit) begin
            stage[4*(5-int'(idx)) +: 4] <= rx_data[3:0];
            if (idx == 3'd5) state <= TERM;
            else idx <= idx + 1'b1;
          end else begin
            state     <= IDLE;
            cmd_error <= 1'b1;
            err_code  <= 2'd0;
          end
          TERM: begin
            state <= IDLE;
            if (is_eol && range_ok) begin
              set_time  <= stage;
              set_valid <= 1'b1;
            end else begin
              cmd_error <= 1'b1;
              err_code  <= is_eol ? 2'd1 : 2'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state     <= IDLE;
        cmd_error <= 1'b1;
        err_code  <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_uart_time_cmd.sv
// tb_uart_time_cmd: randomized and directed checks of uart_time_cmd against a frame-level model.
module tb_uart_time_cmd;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, framing_error = 1'b0;
  logic        oversample_tick, set_valid, cmd_error, busy;
  logic [23:0] set_time;
  logic [1:0]  err_code;
  int          compared = 0, mismatched = 0;
  bit          in_frame = 0, e_sv = 0, e_err = 0;
  logic [7:0]  frm[$];
  logic [23:0] m_time = '0;
  logic [1:0]  m_code = '0;

  uart_time_cmd dut (
    .clk(clk), .reset_n(reset_n), .oversample_tick(oversample_tick),
    .rx_data(rx_data), .rx_valid(rx_valid), .framing_error(framing_error),
    .set_valid(set_valid), .set_time(set_time), .cmd_error(cmd_error),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; holds the strobes for one cycle and returns at the next negedge.
  task automatic drive(input logic [7:0] b, input bit v, input bit fe);
    rx_data = b;
    rx_valid = v;
    framing_error = fe;
    @(negedge clk);
    rx_valid = 1'b0;
    framing_error = 1'b0;
  endtask

  // Frame-level reference: collects the bytes after 'T' and judges the frame by position.
  task automatic model(input logic [7:0] b, input bit v, input bit fe);
    logic [7:0] d;
    int hours;
    e_sv = 0;
    e_err = 0;
    if (fe) begin
      if (in_frame) begin e_err = 1; m_code = 2; in_frame = 0; end
    end else if (v) begin
      if (!in_frame) begin
        if (b == "T" || b == "t") begin in_frame = 1; frm.delete(); end
      end else begin
        frm.push_back(b);
        if (frm.size() <= 6) begin
          if (b < "0" || b > "9") begin e_err = 1; m_code = 0; in_frame = 0; end
        end else begin
          in_frame = 0;
          hours = (int'(frm[0]) - 48) * 10 + (int'(frm[1]) - 48);
          if (b != 8'h0d && b != 8'h0a) begin e_err = 1; m_code = 0; end
          else if (hours <= 23 && frm[2] <= "5" && frm[4] <= "5") begin
            e_sv = 1;
            for (int i = 0; i < 6; i++) begin d = frm[i]; m_time = {m_time[19:0], d[3:0]}; end
          end else begin e_err = 1; m_code = 1; end
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({oversample_tick, set_valid, cmd_error, busy, set_time, err_code} !== 30'd0) begin
      mismatched++;
      $display("FAIL reset: got tick%b sv%b er%b bz%b t%h c%0d want all zero",
               oversample_tick, set_valid, cmd_error, busy, set_time, err_code);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tick;
    int gap = 0, w = 0;
    while (!oversample_tick && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    compared++;
    if (oversample_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL tick_width: got %b want 0 one clock after tick", oversample_tick);
    end
    gap = 1;
    while (!oversample_tick && gap < 100) begin @(negedge clk); gap++; end
    compared++;
    if (gap != 27) begin
      mismatched++;
      $display("FAIL tick_period: got %0d want 27", gap);
    end
  endtask

  task automatic test_directed;
    string frames[6] = '{"T123456\r", "T245959\n", "T235959\n", "T12a", "t000000\r", "T010203\n"};
    foreach (frames[f]) begin
      for (int i = 0; i < frames[f].len(); i++) begin
        drive(frames[f][i], 1, 0);
        model(frames[f][i], 1, 0);
        compared++;
        if ({set_valid, cmd_error, busy, set_time, err_code} !== {e_sv, e_err, in_frame, m_time, m_code}) begin
          mismatched++;
          $display("FAIL directed f%0d b%0d: got sv%b er%b bz%b t%h c%0d want sv%b er%b bz%b t%h c%0d",
                   f, i, set_valid, cmd_error, busy, set_time, err_code, e_sv, e_err, in_frame, m_time, m_code);
        end
      end
    end
    @(negedge clk);
    compared++;
    if ({set_valid, cmd_error, set_time} !== {2'b00, 24'h010203}) begin
      mismatched++;
      $display("FAIL directed_tail: got sv%b er%b t%h want sv0 er0 t010203", set_valid, cmd_error, set_time);
    end
  endtask

  task automatic test_framing;
    logic [8:0] seq[$] = '{9'h054, 9'h031, 9'h032, 9'h100, 9'h054, 9'h031, 9'h032, 9'h133,
                           9'h100, 9'h154, 9'h031, 9'h054, 9'h100};
    foreach (seq[i]) begin
      drive(seq[i][7:0], !seq[i][8] || seq[i][7:0] != 8'h00, seq[i][8]);
      model(seq[i][7:0], !seq[i][8] || seq[i][7:0] != 8'h00, seq[i][8]);
      compared++;
      if ({set_valid, cmd_error, busy, set_time, err_code} !== {e_sv, e_err, in_frame, m_time, m_code}) begin
        mismatched++;
        $display("FAIL framing s%0d: got sv%b er%b bz%b t%h c%0d want sv%b er%b bz%b t%h c%0d",
                 i, set_valid, cmd_error, busy, set_time, err_code, e_sv, e_err, in_frame, m_time, m_code);
      end
    end
  endtask

  task automatic test_timeout;
    string s = "T12";
    int n = 0, cyc = 0;
    bit early = 0;
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1, 0);
      model(s[i], 1, 0);
    end
    while (n < 1600 && cyc < 50000) begin
      if (cmd_error) early = 1;
      if (oversample_tick) n++;
      if (n < 1600) begin @(negedge clk); cyc++; end
    end
    @(negedge clk);
    in_frame = 0;
    m_code = 3;
    compared++;
    if ({early, cmd_error, err_code, busy, set_valid} !== {1'b0, 1'b1, 2'd3, 1'b0, 1'b0} || n != 1600) begin
      mismatched++;
      $display("FAIL timeout: got early%b er%b c%0d bz%b sv%b ticks%0d want early0 er1 c3 bz0 sv0 ticks1600",
               early, cmd_error, err_code, busy, set_valid, n);
    end
    @(negedge clk);
    compared++;
    if (cmd_error !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_width: got %b want 0", cmd_error);
    end
  endtask

  task automatic test_reset_mid;
    string a = "T1234", b = "T010203\r";
    for (int i = 0; i < a.len(); i++) begin
      drive(a[i], 1, 0);
      model(a[i], 1, 0);
    end
    #2 reset_n = 1'b0;
    #1;
    in_frame = 0; m_time = '0; m_code = 0;
    compared++;
    if ({oversample_tick, set_valid, cmd_error, busy, set_time, err_code} !== 30'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got tick%b sv%b er%b bz%b t%h c%0d want all zero",
               oversample_tick, set_valid, cmd_error, busy, set_time, err_code);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < b.len(); i++) begin
      drive(b[i], 1, 0);
      model(b[i], 1, 0);
      compared++;
      if ({set_valid, cmd_error, busy, set_time, err_code} !== {e_sv, e_err, in_frame, m_time, m_code}) begin
        mismatched++;
        $display("FAIL after_reset b%0d: got sv%b er%b bz%b t%h c%0d want sv%b er%b bz%b t%h c%0d",
                 i, set_valid, cmd_error, busy, set_time, err_code, e_sv, e_err, in_frame, m_time, m_code);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] q[$];
    logic [7:0] b;
    bit v, fe;
    repeat (80) begin
      q.delete();
      q.push_back($urandom_range(0, 1) ? 9'h054 : 9'h074);
      q.push_back(9'(8'h30 + $urandom_range(0, 2)));
      for (int i = 1; i < 6; i++) q.push_back(9'(8'h30 + $urandom_range(0, (i % 2) ? 9 : 6)));
      q.push_back($urandom_range(0, 1) ? 9'h00d : 9'h00a);
      case ($urandom_range(0, 5))
        0: q[$urandom_range(0, 7)] = 9'($urandom_range(0, 255));
        1: begin q = q[0:$urandom_range(0, 6)]; q.push_back(9'h100 | 9'($urandom_range(0, 1) ? 8'h35 : 8'h00)); end
        2: q.push_front(9'($urandom_range(0, 255)));
        default: ;
      endcase
      foreach (q[i]) begin
        repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
          @(negedge clk);
          e_sv = 0;
          e_err = 0;
          compared++;
          if ({set_valid, cmd_error, busy, set_time, err_code} !== {e_sv, e_err, in_frame, m_time, m_code}) begin
            mismatched++;
            $display("FAIL gap: got sv%b er%b bz%b t%h c%0d want sv0 er0 bz%b t%h c%0d",
                     set_valid, cmd_error, busy, set_time, err_code, in_frame, m_time, m_code);
          end
        end
        b = q[i][7:0];
        fe = q[i][8];
        v = !fe || b != 8'h00;
        drive(b, v, fe);
        model(b, v, fe);
        compared++;
        if ({set_valid, cmd_error, busy, set_time, err_code} !== {e_sv, e_err, in_frame, m_time, m_code}) begin
          mismatched++;
          $display("FAIL random b=%h v%b fe%b: got sv%b er%b bz%b t%h c%0d want sv%b er%b bz%b t%h c%0d",
                   b, v, fe, set_valid, cmd_error, busy, set_time, err_code, e_sv, e_err, in_frame, m_time, m_code);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_tick;
    test_directed;
    test_framing;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
